// File: rtl/mem_bist_ctrl_if.sv
// rtl/mem_bist_ctrl_if.sv - control/status and memory-side signals of the BIST master
interface mem_bist_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 8
);
  logic              start;
  logic [WIDTH-1:0]  seed;
  logic [ADDR-1:0]   mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_wrbar;
  logic [WIDTH-1:0]  mem_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR:0]     err_count;
  logic [ADDR-1:0]   fail_addr;

  modport master (
    output start, seed, mem_rdata,
    input  mem_addr, mem_wdata, mem_wrbar, busy, done, pass, err_count, fail_addr
  );

  modport slave (
    input  start, seed, mem_rdata,
    output mem_addr, mem_wdata, mem_wrbar, busy, done, pass, err_count, fail_addr
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - LFSR write/read-compare BIST master for a single-port synchronous memory
module mem_bist_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR   = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_bist_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR-1:0] LAST_ADDR  = ADDR'(DEPTH - 1);
  localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR-1:0]   cnt_q, cnt_d;
  logic [2:0]        drain_q, drain_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [ADDR:0]     err_q, err_d;
  logic [ADDR-1:0]   fail_q, fail_d;
  logic              pass_q, pass_d;

  // Expected word/address travel alongside the memory read latency.
  logic [RD_LAT-1:0] pvld_q;
  logic [WIDTH-1:0]  pdata_q [RD_LAT];
  logic [ADDR-1:0]   paddr_q [RD_LAT];

  logic              mismatch;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
  endfunction

  assign mismatch = pvld_q[RD_LAT-1] && (bus.mem_rdata != pdata_q[RD_LAT-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    if (mismatch) begin
      if (err_q == '0) begin
        fail_d = paddr_q[RD_LAT-1];
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          seed_d  = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
          lfsr_d  = seed_d;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        lfsr_d = lfsr_next(lfsr_q);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          lfsr_d  = seed_q;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        lfsr_d = lfsr_next(lfsr_q);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          // The last compare resolves in this cycle, so judge on err_d.
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      drain_q <= '0;
      lfsr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      pvld_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
      pvld_q[0]  <= (state_q == S_READ);
      for (int i = 1; i < RD_LAT; i++) begin
        pvld_q[i] <= pvld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pdata_q[0] <= lfsr_q;
    paddr_q[0] <= cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pdata_q[i] <= pdata_q[i-1];
      paddr_q[i] <= paddr_q[i-1];
    end
  end

  assign bus.mem_wrbar = (state_q == S_WRITE);
  assign bus.mem_addr  = ((state_q == S_WRITE) || (state_q == S_READ)) ? cnt_q : '0;
  assign bus.mem_wdata = (state_q == S_WRITE) ? lfsr_q : '0;
  assign bus.busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_addr = fail_q;

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test master for the single-port synchronous memory (the `memory` block).
- Drives the memory's address, write-data and write-strobe lines.
- Fills every location with a pseudo-random sequence, then reads every location back and compares against the regenerated sequence.
- Reports pass/fail, the first failing address and the error count; sits between the test/control logic and the memory instance.

Parameters:
- WIDTH, 32, memory data width in bits (fixed at 32 by the LFSR definition).
- DEPTH, 256, number of locations tested; addresses 0..DEPTH-1; DEPTH <= 2**ADDR.
- ADDR, 8, memory address width.
- RD_LAT, 1, cycles from read address presented (mem_wrbar=0) to valid mem_rdata; legal range 1..4.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a test when in IDLE, ignored otherwise.
- seed  input  WIDTH  LFSR seed, sampled on accepted start; 0 is replaced by 32'h00000001.
- mem_addr  output  ADDR  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_wrbar  output  1  1 = write, 0 = read.
- mem_rdata  input  WIDTH  memory read data.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at test completion.
- pass  output  1  valid after done; held until next accepted start.
- err_count  output  ADDR+1  number of miscompares, saturating at all-ones.
- fail_addr  output  ADDR  address of the first miscompare; 0 if none.

Behaviour:
- Reset (sync, rst=1 at edge):
  - State -> IDLE.
  - mem_addr=0, mem_wdata=0, mem_wrbar=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0.
  - Reset mid-test aborts immediately; no further writes are issued.
- LFSR (Fibonacci): next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
  - Word for address 0 = seed (after zero substitution).
  - Word for address k+1 = next(word k).
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - Outputs held, mem_wrbar=0.
  - On start=1: load seed into LFSR, clear err_count/fail_addr/pass, set busy=1, go WRITE.
- WRITE: one location per cycle, DEPTH cycles.
  - mem_wrbar=1, mem_addr=k, mem_wdata=word k.
  - After address DEPTH-1, reload LFSR with the sampled seed and go READ.
  - No idle cycle between the last write and the first read.
- READ: one location per cycle, DEPTH cycles.
  - mem_wrbar=0, mem_addr=k, mem_wdata=0.
  - Expected word and address are pushed into an RD_LAT-deep delay pipe.
  - Compare mem_rdata with the pipe output RD_LAT cycles after issue.
  - After address DEPTH-1, go DRAIN.
- DRAIN:
  - Lasts RD_LAT cycles; mem_wrbar=0, mem_addr=0.
  - Outstanding compares complete; then go DONE.
- On each compare mismatch:
  - err_count increments, saturating.
  - If it was the first error, fail_addr = delayed address.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_count==0 including any compare resolved this cycle).
  - Next state IDLE.
- start while busy is ignored and does not restart the test.
- Total test length from accepted start to done = 2*DEPTH + RD_LAT + 1 cycles.
- mem_wrbar is never 1 outside WRITE.

Test Plan:
- Fault-free run: behavioural memory with RD_LAT=1, seed=1, DEPTH=256, start pulse.
  - First writes: addr0=0x00000001, addr1=0x00000003, addr2=0x00000006.
  - done exactly 514 cycles after start; pass=1, err_count=0, fail_addr=0.
- Zero seed: seed=0 behaves identically to seed=1 (same write sequence, pass=1).
- Stuck bit: memory model forces bit 5 of location 0x37 to 0 on a seed whose word for 0x37 has bit5=1.
  - Expect pass=0, err_count=1, fail_addr=0x37.
- Multiple faults: locations 0x10 and 0xF0 corrupted.
  - Expect err_count=2, fail_addr=0x10.
- Start while busy: second start pulse mid-WRITE and mid-READ.
  - Ignored; done timing and results unchanged.
  - A start after done reruns the test and clears the previous results.
- Reset mid-WRITE at address 0x80:
  - Next cycle mem_wrbar=0, busy=0, all outputs at reset values.
  - A fresh start then completes with pass=1.
  - Repeat the fault-free run with RD_LAT=3: done at 516 cycles, pass=1.
